// File: rtl/bit_serial_lu_ctrl_if.sv
// Handshake and bit-stream bundle between the serial logic-unit sequencer,
// its upstream producer, its downstream consumer and the 1-bit mfu.
interface bit_serial_lu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             mfu_a;
  logic             mfu_b;
  logic [2:0]       mfu_sel;
  logic             mfu_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  // The sequencer itself.
  modport slave (
    input  in_valid, op_a, op_b, op_sel, mfu_y, out_ready,
    output in_ready, mfu_a, mfu_b, mfu_sel, out_valid, result, busy
  );

  // Everything around it: producer, consumer and the mfu.
  modport master (
    output in_valid, op_a, op_b, op_sel, mfu_y, out_ready,
    input  in_ready, mfu_a, mfu_b, mfu_sel, out_valid, result, busy
  );
endinterface

// File: rtl/bit_serial_lu_ctrl.sv
// Sequencer for the 1-bit mfu: latches an operand pair, streams it LSB-first
// through the mfu and reassembles the returned bits into a WIDTH-bit result.
module bit_serial_lu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serial_lu_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [2:0]       sel_reg;
  logic [CW-1:0]    cnt;

  // Data registers are reset as well: a reset must leave result at zero and
  // discard any half-streamed operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      sel_reg <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg   <= bus.op_a;
            b_reg   <= bus.op_b;
            sel_reg <= bus.op_sel;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // mfu_y returns f(a_reg[0], b_reg[0]) this cycle; it enters at the
          // MSB so that after WIDTH shifts bit i lands at position i.
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= {bus.mfu_y, res_reg[WIDTH-1:1]};
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = res_reg;

  // The mfu is parked at AND with zero inputs whenever nothing is streaming.
  assign bus.mfu_a     = (state == SHIFT) ? a_reg[0] : 1'b0;
  assign bus.mfu_b     = (state == SHIFT) ? b_reg[0] : 1'b0;
  assign bus.mfu_sel   = (state == SHIFT) ? sel_reg  : 3'b000;

endmodule

// File: tb/tb_bit_serial_lu_ctrl.sv
// Directed bench for bit_serial_lu_ctrl with a behavioural 1-bit mfu attached.
module tb_bit_serial_lu_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  bit_serial_lu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_lu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational mfu: answers in the same cycle it is driven.
  always_comb begin
    bus.mfu_y = 1'b0;
    case (bus.mfu_sel)
      3'b000: bus.mfu_y = bus.mfu_a & bus.mfu_b;
      3'b001: bus.mfu_y = bus.mfu_a | bus.mfu_b;
      3'b010: bus.mfu_y = ~bus.mfu_a;
      3'b011: bus.mfu_y = ~(bus.mfu_a & bus.mfu_b);
      3'b100: bus.mfu_y = ~(bus.mfu_a | bus.mfu_b);
      3'b101: bus.mfu_y = bus.mfu_a ^ bus.mfu_b;
      3'b110: bus.mfu_y = ~(bus.mfu_a ^ bus.mfu_b);
      default: bus.mfu_y = 1'b0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation in IDLE and returns in the first SHIFT cycle.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] sel);
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sel   = sel;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.op_sel   = 3'b000;
  endtask

  task automatic shift_phase(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [2:0] sel);
    for (int k = 0; k < WIDTH; k++) begin
      chk("shift_busy",      {31'd0, bus.busy},      32'd1);
      chk("shift_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("shift_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("shift_mfu_a",     {31'd0, bus.mfu_a},     {31'd0, a[k]});
      chk("shift_mfu_b",     {31'd0, bus.mfu_b},     {31'd0, b[k]});
      chk("shift_mfu_sel",   {29'd0, bus.mfu_sel},   {29'd0, sel});
      tick();
    end
  endtask

  task automatic done_phase(input logic [WIDTH-1:0] exp);
    chk("done_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("done_result",    {24'd0, bus.result},    {24'd0, exp});
    chk("done_busy",      {31'd0, bus.busy},      32'd1);
    chk("done_mfu_sel",   {29'd0, bus.mfu_sel},   32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("post_busy",      {31'd0, bus.busy},      32'd0);
    chk("post_result",    {24'd0, bus.result},    {24'd0, exp});
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] sel, input logic [WIDTH-1:0] exp);
    start_op(a, b, sel);
    shift_phase(a, b, sel);
    done_phase(exp);
  endtask

  initial begin
    int acc[$];
    nvec          = 0;
    nerr          = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = 3'b000;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_result",    {24'd0, bus.result},    32'h00);
    chk("rst_mfu_a",     {31'd0, bus.mfu_a},     32'd0);
    chk("rst_mfu_b",     {31'd0, bus.mfu_b},     32'd0);
    chk("rst_mfu_sel",   {29'd0, bus.mfu_sel},   32'd0);

    // AND, NOT, XOR, XNOR
    do_op(8'hF0, 8'h3C, 3'b000, 8'h30);
    do_op(8'hA5, 8'hFF, 3'b010, 8'h5A);
    do_op(8'hA5, 8'h0F, 3'b101, 8'hAA);
    do_op(8'h55, 8'h0F, 3'b110, 8'hA5);

    // NOR with backpressure held in DONE
    start_op(8'h0F, 8'h30, 3'b100);
    shift_phase(8'h0F, 8'h30, 3'b100);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.op_a     = 8'hFF;
      bus.op_sel   = 3'b001;
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_result",    {24'd0, bus.result},    32'hC0);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      tick();
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_no_accept_busy", {31'd0, bus.busy},      32'd0);
    chk("bp_idle_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("bp_idle_result",    {24'd0, bus.result},    32'hC0);

    // Reset during the 4th SHIFT cycle
    start_op(8'hFF, 8'hFF, 3'b000);
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_busy",      {31'd0, bus.busy},      32'd0);
    chk("midrst_result",    {24'd0, bus.result},    32'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    do_op(8'hFF, 8'h0F, 3'b011, 8'hF0);

    // Constant-zero opcode
    do_op(8'hFF, 8'hFF, 3'b111, 8'h00);

    // Back-to-back: OR 12|40 = 52, accepts every 10 cycles
    bus.op_a      = 8'h12;
    bus.op_b      = 8'h40;
    bus.op_sel    = 3'b001;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (bus.in_ready && bus.in_valid) acc.push_back(cyc);
      if (bus.out_valid) chk("b2b_result", {24'd0, bus.result}, 32'h52);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_accepts", acc.size(), 32'd5);
    for (int i = 1; i < acc.size(); i++) begin
      chk("b2b_spacing", acc[i] - acc[i-1], 32'd10);
    end
    shift_phase(8'h12, 8'h40, 3'b001);
    done_phase(8'h52);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
